// File: rtl/mesh_network_interface.sv
// Generic synchronous FIFO with registered occupancy, used by both NI paths.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: full_o is derived from registered state only; push when full and pop when empty are ignored.
module mesh_ni_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

// Mesh endpoint NI: queues PE sends into the router, filters and queues router ejections for the PE.
// Latency: 1 cycle from PE handshake to noc_valid_o, 1 cycle from router accept to rx_valid_o.
// Backpressure: tx_ready_o / noc_ready_o are !full of their queue, registered only, so no combinational valid->ready paths.
module mesh_network_interface #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int TX_DEPTH     = 4,
    parameter int RX_DEPTH     = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [X_ADDR_WIDTH-1:0] local_x_addr,
    input  logic [Y_ADDR_WIDTH-1:0] local_y_addr,
    input  logic                    tx_valid_i,
    input  logic [X_ADDR_WIDTH-1:0] tx_dest_x_i,
    input  logic [Y_ADDR_WIDTH-1:0] tx_dest_y_i,
    input  logic [DATA_WIDTH-1:0]   tx_data_i,
    output logic                    tx_ready_o,
    output logic                    noc_valid_o,
    output logic [DATA_WIDTH-1:0]   noc_data_o,
    output logic [ADDR_WIDTH-1:0]   noc_addr_o,
    input  logic                    noc_ready_i,
    input  logic                    noc_valid_i,
    input  logic [DATA_WIDTH-1:0]   noc_data_i,
    input  logic [ADDR_WIDTH-1:0]   noc_addr_i,
    output logic                    noc_ready_o,
    output logic                    rx_valid_o,
    output logic [DATA_WIDTH-1:0]   rx_data_o,
    output logic [ADDR_WIDTH-1:0]   rx_addr_o,
    input  logic                    rx_ready_i,
    input  logic                    status_clr_i,
    output logic [CNT_WIDTH-1:0]    tx_count_o,
    output logic [CNT_WIDTH-1:0]    rx_count_o,
    output logic [CNT_WIDTH-1:0]    drop_count_o,
    output logic                    misroute_o
);
    localparam int PKT_W = ADDR_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } pkt_t;

    pkt_t tx_pkt_in, tx_head, rx_pkt_in, rx_head;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_accept, rx_push, rx_drop, rx_pop, addr_match;

    logic [CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                 misroute_q, misroute_d;

    // X in the MSBs, Y just below, any remaining LSBs zero.
    always_comb begin
        tx_pkt_in      = '0;
        tx_pkt_in.data = tx_data_i;
        tx_pkt_in.addr[ADDR_WIDTH-1 -: X_ADDR_WIDTH]              = tx_dest_x_i;
        tx_pkt_in.addr[ADDR_WIDTH-X_ADDR_WIDTH-1 -: Y_ADDR_WIDTH] = tx_dest_y_i;
    end

    assign tx_ready_o  = !tx_full;
    assign tx_push     = tx_valid_i && tx_ready_o;
    assign noc_valid_o = !tx_empty;
    assign noc_data_o  = tx_head.data;
    assign noc_addr_o  = tx_head.addr;
    assign tx_pop      = noc_valid_o && noc_ready_i;

    mesh_ni_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (tx_push),
        .push_dat_i (tx_pkt_in),
        .pop_i      (tx_pop),
        .pop_dat_o  (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty)
    );

    assign rx_pkt_in.addr = noc_addr_i;
    assign rx_pkt_in.data = noc_data_i;
    assign addr_match = (noc_addr_i[ADDR_WIDTH-1 -: X_ADDR_WIDTH] == local_x_addr) &&
                        (noc_addr_i[ADDR_WIDTH-X_ADDR_WIDTH-1 -: Y_ADDR_WIDTH] == local_y_addr);

    assign noc_ready_o = !rx_full;
    assign rx_accept   = noc_valid_i && noc_ready_o;
    assign rx_push     = rx_accept && addr_match;
    assign rx_drop     = rx_accept && !addr_match;
    assign rx_valid_o  = !rx_empty;
    assign rx_data_o   = rx_head.data;
    assign rx_addr_o   = rx_head.addr;
    assign rx_pop      = rx_valid_o && rx_ready_i;

    mesh_ni_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rx_push),
        .push_dat_i (rx_pkt_in),
        .pop_i      (rx_pop),
        .pop_dat_o  (rx_head),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

    // Clear has priority over any increment or misroute set in the same cycle.
    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        drop_cnt_d = drop_cnt_q;
        misroute_d = misroute_q;
        if (status_clr_i) begin
            tx_cnt_d   = '0;
            rx_cnt_d   = '0;
            drop_cnt_d = '0;
            misroute_d = 1'b0;
        end else begin
            if (tx_pop)  tx_cnt_d = tx_cnt_q + CNT_WIDTH'(1);
            if (rx_push) rx_cnt_d = rx_cnt_q + CNT_WIDTH'(1);
            if (rx_drop) begin
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                misroute_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
            misroute_q <= 1'b0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            misroute_q <= misroute_d;
        end
    end

    assign tx_count_o   = tx_cnt_q;
    assign rx_count_o   = rx_cnt_q;
    assign drop_count_o = drop_cnt_q;
    assign misroute_o   = misroute_q;
endmodule

// File: tb/tb_mesh_network_interface.sv
// Directed bench for mesh_network_interface at node (2,3): inputs change and outputs are checked 1ns after each rising edge.
module tb_mesh_network_interface;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  local_x_addr, local_y_addr;
    logic        tx_valid_i;
    logic [3:0]  tx_dest_x_i, tx_dest_y_i;
    logic [31:0] tx_data_i;
    logic        tx_ready_o;
    logic        noc_valid_o;
    logic [31:0] noc_data_o;
    logic [7:0]  noc_addr_o;
    logic        noc_ready_i;
    logic        noc_valid_i;
    logic [31:0] noc_data_i;
    logic [7:0]  noc_addr_i;
    logic        noc_ready_o;
    logic        rx_valid_o;
    logic [31:0] rx_data_o;
    logic [7:0]  rx_addr_o;
    logic        rx_ready_i;
    logic        status_clr_i;
    logic [15:0] tx_count_o, rx_count_o, drop_count_o;
    logic        misroute_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mesh_network_interface dut (
        .clk          (clk),
        .rst          (rst),
        .local_x_addr (local_x_addr),
        .local_y_addr (local_y_addr),
        .tx_valid_i   (tx_valid_i),
        .tx_dest_x_i  (tx_dest_x_i),
        .tx_dest_y_i  (tx_dest_y_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .noc_valid_o  (noc_valid_o),
        .noc_data_o   (noc_data_o),
        .noc_addr_o   (noc_addr_o),
        .noc_ready_i  (noc_ready_i),
        .noc_valid_i  (noc_valid_i),
        .noc_data_i   (noc_data_i),
        .noc_addr_i   (noc_addr_i),
        .noc_ready_o  (noc_ready_o),
        .rx_valid_o   (rx_valid_o),
        .rx_data_o    (rx_data_o),
        .rx_addr_o    (rx_addr_o),
        .rx_ready_i   (rx_ready_i),
        .status_clr_i (status_clr_i),
        .tx_count_o   (tx_count_o),
        .rx_count_o   (rx_count_o),
        .drop_count_o (drop_count_o),
        .misroute_o   (misroute_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  got;
        int  offer;
        logic acc;

        rst = 1'b1;
        local_x_addr = 4'd2;
        local_y_addr = 4'd3;
        tx_valid_i = 1'b0; tx_dest_x_i = '0; tx_dest_y_i = '0; tx_data_i = '0;
        noc_ready_i = 1'b0; noc_valid_i = 1'b0; noc_data_i = '0; noc_addr_i = '0;
        rx_ready_i = 1'b0; status_clr_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_noc_valid", noc_valid_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_noc_ready", noc_ready_o, 1);
        check("rst_counts", {tx_count_o, rx_count_o}, 0);
        check("rst_drop_misroute", {drop_count_o, 15'd0, misroute_o}, 0);

        // Single send to (5,1)
        noc_ready_i = 1'b1;
        tx_valid_i = 1'b1; tx_dest_x_i = 4'd5; tx_dest_y_i = 4'd1; tx_data_i = 32'hDEADBEEF;
        tick();
        tx_valid_i = 1'b0;
        check("tx1_valid", noc_valid_o, 1);
        check("tx1_addr", noc_addr_o, 8'h51);
        check("tx1_data", noc_data_o, 32'hDEADBEEF);
        check("tx1_cnt_before", tx_count_o, 0);
        tick();
        check("tx1_cnt", tx_count_o, 1);
        check("tx1_drained", noc_valid_o, 0);

        status_clr_i = 1'b1;
        tick();
        status_clr_i = 1'b0;
        check("clr_tx_cnt", tx_count_o, 0);

        // Fill TX queue under router backpressure
        noc_ready_i = 1'b0;
        tx_dest_x_i = 4'd1; tx_dest_y_i = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tx_valid_i = 1'b1;
            tx_data_i  = 32'h100 + i;
            tick();
            check("tx_full_ready", tx_ready_o, (i < 3) ? 1 : 0);
        end
        tx_valid_i = 1'b0;
        check("tx_stall_data0", noc_data_o, 32'h100);
        tick();
        tick();
        check("tx_stall_data1", noc_data_o, 32'h100);
        check("tx_stall_addr", noc_addr_o, 8'h11);
        check("tx_stall_cnt", tx_count_o, 0);
        noc_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("tx_order_valid", noc_valid_o, 1);
            check("tx_order_data", noc_data_o, 32'h100 + k);
            tick();
        end
        check("tx_empty", noc_valid_o, 0);
        check("tx_cnt4", tx_count_o, 4);
        check("tx_ready_back", tx_ready_o, 1);

        // RX filtering
        rx_ready_i = 1'b1;
        noc_valid_i = 1'b1; noc_addr_i = 8'h23; noc_data_i = 32'h11;
        tick();
        noc_addr_i = 8'h24; noc_data_i = 32'h22;
        check("rx_match_valid", rx_valid_o, 1);
        check("rx_match_data", rx_data_o, 32'h11);
        check("rx_match_addr", rx_addr_o, 8'h23);
        tick();
        noc_valid_i = 1'b0;
        check("rx_drop_novalid", rx_valid_o, 0);
        check("rx_cnt1", rx_count_o, 1);
        check("drop_cnt1", drop_count_o, 1);
        check("misroute1", misroute_o, 1);

        // RX backpressure with six local packets
        got = 0;
        offer = 1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            rx_ready_i = (cyc >= 6);
            if (cyc == 4) check("rx_full_bp", noc_ready_o, 0);
            noc_valid_i = (offer <= 6);
            noc_data_i  = offer;
            noc_addr_i  = 8'h23;
            acc = noc_valid_i && noc_ready_o;
            if (rx_valid_o && rx_ready_i) begin
                check("rx_order", rx_data_o, got + 1);
                got++;
            end
            tick();
            if (acc) offer++;
        end
        noc_valid_i = 1'b0;
        rx_ready_i = 1'b0;
        check("rx_all_delivered", got, 6);
        check("rx_cnt7", rx_count_o, 7);
        check("drop_cnt_still1", drop_count_o, 1);

        // Reset with traffic queued on both paths
        noc_ready_i = 1'b0;
        tx_valid_i = 1'b1; tx_dest_x_i = 4'd2; tx_dest_y_i = 4'd3;
        tx_data_i = 32'hA1; tick();
        tx_data_i = 32'hA2; tick();
        tx_valid_i = 1'b0;
        noc_valid_i = 1'b1; noc_addr_i = 8'h23;
        for (int i = 0; i < 3; i++) begin
            noc_data_i = 32'hB0 + i;
            tick();
        end
        noc_valid_i = 1'b0;
        check("pre_rst_rx_valid", rx_valid_o, 1);
        check("pre_rst_noc_valid", noc_valid_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_noc_valid", noc_valid_o, 0);
        check("mid_rst_rx_valid", rx_valid_o, 0);
        check("mid_rst_counts", {tx_count_o, rx_count_o}, 0);
        check("mid_rst_drop", {drop_count_o, 15'd0, misroute_o}, 0);
        check("mid_rst_readies", {tx_ready_o, noc_ready_o}, 2'b11);
        noc_ready_i = 1'b1;
        tick();
        check("rst_discarded_tx", tx_count_o, 0);

        // rx_count wrap
        rx_ready_i = 1'b1;
        noc_valid_i = 1'b1; noc_addr_i = 8'h23; noc_data_i = 32'h5A;
        for (int i = 0; i < 65535; i++) tick();
        check("rx_cnt_ffff", rx_count_o, 16'hFFFF);
        tick();
        check("rx_cnt_wrap", rx_count_o, 16'h0000);

        // Drop, then drop coincident with clear
        noc_addr_i = 8'h24;
        tick();
        check("drop_before_clr", drop_count_o, 1);
        check("misroute_before_clr", misroute_o, 1);
        status_clr_i = 1'b1;
        tick();
        status_clr_i = 1'b0;
        noc_valid_i = 1'b0;
        check("clr_wins_drop", drop_count_o, 0);
        check("clr_wins_misroute", misroute_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mesh_network_interface.md
Name: mesh_network_interface

Overview:
Endpoint network interface that attaches a processing element (PE) to the local port of a mesh router. The TX path queues PE send requests, packs dest X/Y into the router address field, and injects packets into the router local input. The RX path accepts packets ejected from the router local output, drops any not addressed to this node, and buffers the rest for the PE. It also keeps packet counters and a sticky misroute flag.

Parameters:
DATA_WIDTH, 32, payload width
ADDR_WIDTH, 8, router address width; must be >= X_ADDR_WIDTH+Y_ADDR_WIDTH
X_ADDR_WIDTH, 4, X coordinate width
Y_ADDR_WIDTH, 4, Y coordinate width
TX_DEPTH, 4, TX queue entries (power of 2, >=2)
RX_DEPTH, 4, RX queue entries (power of 2, >=2)
CNT_WIDTH, 16, width of packet counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
local_x_addr  in  X_ADDR_WIDTH  this node's X
local_y_addr  in  Y_ADDR_WIDTH  this node's Y
tx_valid_i  in  1  PE send request
tx_dest_x_i  in  X_ADDR_WIDTH  destination X
tx_dest_y_i  in  Y_ADDR_WIDTH  destination Y
tx_data_i  in  DATA_WIDTH  payload
tx_ready_o  out  1  TX queue can accept
noc_valid_o  out  1  to router local_valid_i
noc_data_o  out  DATA_WIDTH  to router local_data_i
noc_addr_o  out  ADDR_WIDTH  to router local_addr_i
noc_ready_i  in  1  from router local_ready_o
noc_valid_i  in  1  from router local_valid_o
noc_data_i  in  DATA_WIDTH  from router local_data_o
noc_addr_i  in  ADDR_WIDTH  from router local_addr_o
noc_ready_o  out  1  to router local_ready_i
rx_valid_o  out  1  packet available to PE
rx_data_o  out  DATA_WIDTH  received payload
rx_addr_o  out  ADDR_WIDTH  received address field
rx_ready_i  in  1  PE accepts packet
status_clr_i  in  1  clear counters and misroute flag
tx_count_o  out  CNT_WIDTH  packets injected
rx_count_o  out  CNT_WIDTH  packets accepted for this node
drop_count_o  out  CNT_WIDTH  misrouted packets dropped
misroute_o  out  1  sticky: any misrouted packet seen

Behaviour:
- Reset is synchronous and active-high. It empties both queues and zeroes all counters and misroute_o. After reset, noc_valid_o=0 and rx_valid_o=0. tx_ready_o=1 and noc_ready_o=1 from the first cycle after reset deasserts. Reset mid-operation discards all queued packets.
- Address packing: noc_addr = {dest_x, dest_y, zeros}. X occupies the MSBs, Y the next Y_ADDR_WIDTH bits, and the remaining LSBs are 0.
- Transfers occur on valid&&ready at the rising edge. A valid source holds valid, data and addr stable until the handshake completes.
- TX path:
  - tx_ready_o = !tx_full. There is no full-bypass.
  - On push, the packed packet is written to the queue.
  - noc_valid_o = !tx_empty, with data/addr taken from the queue head.
  - Latency is 1 cycle from tx handshake to noc_valid_o when the queue is empty.
  - noc_valid_o must not depend combinationally on noc_ready_i.
  - Push and pop in the same cycle leave the count unchanged.
- RX path:
  - noc_ready_o = !rx_full.
  - noc_ready_o must not depend combinationally on noc_valid_i, because the router gates its valid with our ready.
  - On accept, compare addr X/Y with local_x_addr/local_y_addr.
    - Match: write to the RX queue and increment rx_count_o.
    - Mismatch: do not enqueue, increment drop_count_o, set misroute_o.
  - rx_valid_o = !rx_empty, with head data/addr. Pop on rx_valid_o&&rx_ready_i.
  - Simultaneous accept and pop on a full queue cannot occur, since noc_ready_o=0 when full.
- Ordering: FIFO within each path; no reordering.
- Counters:
  - tx_count_o increments on each noc_valid_o&&noc_ready_i.
  - All counters wrap modulo 2^CNT_WIDTH.
  - status_clr_i zeroes the counters and misroute_o next cycle; clear wins over a coincident increment or set.
- Pointers wrap at DEPTH-1 to 0. Occupancy counters are $clog2(DEPTH)+1 bits wide.
- Loopback: a dest equal to the local node is sent normally; the router returns it via the RX path.

Test Plan:
1. Node (2,3). Send dest (5,1) with data 0xDEADBEEF, noc_ready_i=1 -> next cycle noc_valid_o=1, noc_addr_o=0x51, noc_data_o=0xDEADBEEF; one cycle later tx_count_o=1.
2. noc_ready_i=0, push 5 packets -> tx_ready_o=0 after the 4th. Release ready -> 4 packets emerge in order, with data stable during stall; tx_count_o=4.
3. Router delivers addr 0x23 with data 0x11, then 0x24 with data 0x22; rx_ready_i=1 -> PE sees only 0x11, rx_count_o=1, drop_count_o=1, misroute_o=1.
4. rx_ready_i=0, 6 valid local packets offered -> noc_ready_o drops after 4. Release -> packets 1..6 delivered in order, none lost.
5. Mid-stream (2 in TX, 3 in RX), pulse rst one cycle -> next cycle noc_valid_o=0, rx_valid_o=0, all counters 0, both readies 1.
6. rx_count_o=0xFFFF plus one accept -> 0x0000. Assert status_clr_i on the same cycle as a drop -> drop_count_o=0, misroute_o=0.
